// File: rtl/video_stream_framer.sv
// Packs active video words into a line/frame stream with EAV/SAV timing headers.
// One registered output word per clock; position counters drive headers and blanking.
module video_stream_framer #(
  parameter int unsigned HACTIVE     = 360,
  parameter int unsigned HBLANK      = 67,
  parameter int unsigned TOTAL_LINES = 525,
  parameter int unsigned F1_START    = 263,
  parameter int unsigned V0_END      = 19,
  parameter int unsigned V1_END      = 282,
  parameter bit          INTERLACED  = 1'b1,
  parameter logic [31:0] BLANK_WORD  = 32'h10801080
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [31:0]                    din,
  input  logic                           dvalid,
  input  logic                           clear_err,
  output logic [31:0]                    dout,
  output logic                           dreq,
  output logic [$clog2(TOTAL_LINES)-1:0] line,
  output logic                           field_odd,
  output logic                           vblank,
  output logic                           hactive,
  output logic                           frame_start,
  output logic                           underflow
);

  localparam int unsigned WORDS  = HACTIVE + HBLANK + 2;
  localparam int unsigned WPOS_W = $clog2(WORDS);
  localparam int unsigned LPOS_W = $clog2(TOTAL_LINES);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic [WPOS_W-1:0] wpos_q;
  logic [LPOS_W-1:0] lpos_q;

  logic [31:0] wpos_ext;
  logic [31:0] lpos_ext;
  logic        f;
  logic        v;
  logic        is_eav;
  logic        is_sav;
  logic        is_active;
  logic        last_word;
  logic        last_line;
  logic        running;
  logic [31:0] header;
  logic [31:0] word;

  always_comb begin
    wpos_ext  = 32'(wpos_q);
    lpos_ext  = 32'(lpos_q);
    f         = INTERLACED && (lpos_ext >= F1_START);
    v         = (lpos_ext < V0_END) || ((lpos_ext >= F1_START) && (lpos_ext < V1_END));
    is_eav    = (wpos_ext == 32'd0);
    is_sav    = (wpos_ext == HBLANK + 1);
    is_active = (wpos_ext >= HBLANK + 2);
    last_word = (wpos_ext == WORDS - 1);
    last_line = (lpos_ext == TOTAL_LINES - 1);
    // H is 1 only on EAV; the header is used on EAV and SAV alone.
    header    = {1'b1, f, v, is_eav, v ^ is_eav, f ^ is_eav, f ^ v, f ^ v ^ is_eav, 24'h0000FF};
  end

  assign dreq = (state_q == StRun) && is_active && !v;

  // Idle with enable already emits the line-0 EAV, so the stream starts on the next edge.
  assign running = (state_q == StRun) || enable;

  always_comb begin
    word = BLANK_WORD;
    if (is_eav || is_sav) begin
      word = header;
    end else if (dreq && dvalid) begin
      word = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wpos_q      <= '0;
      lpos_q      <= '0;
      dout        <= BLANK_WORD;
      line        <= '0;
      field_odd   <= 1'b0;
      vblank      <= 1'b0;
      hactive     <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      // Set has priority over a simultaneous clear.
      underflow <= (dreq && !dvalid) || (underflow && !clear_err);
      if (running) begin
        dout        <= word;
        line        <= lpos_q;
        field_odd   <= f;
        vblank      <= v;
        hactive     <= is_active;
        frame_start <= is_eav && (lpos_q == '0);
        state_q     <= StRun;
        if (last_word) begin
          wpos_q <= '0;
          if (last_line) begin
            lpos_q <= '0;
            if (!enable) begin
              state_q <= StIdle;
            end
          end else begin
            lpos_q <= lpos_q + LPOS_W'(1);
          end
        end else begin
          wpos_q <= wpos_q + WPOS_W'(1);
        end
      end else begin
        state_q     <= StIdle;
        wpos_q      <= '0;
        lpos_q      <= '0;
        dout        <= BLANK_WORD;
        line        <= '0;
        field_odd   <= 1'b0;
        vblank      <= 1'b0;
        hactive     <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_framer.sv
// Directed bench for video_stream_framer on a small 8-word x 6-line interlaced raster.
module tb_video_stream_framer;

  localparam logic [31:0] BLANK = 32'h10801080;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] din;
  logic        dvalid;
  logic        clear_err;
  logic [31:0] dout;
  logic        dreq;
  logic [2:0]  line;
  logic        field_odd;
  logic        vblank;
  logic        hactive;
  logic        frame_start;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  video_stream_framer #(
    .HACTIVE    (4),
    .HBLANK     (2),
    .TOTAL_LINES(6),
    .F1_START   (3),
    .V0_END     (1),
    .V1_END     (4),
    .INTERLACED (1'b1),
    .BLANK_WORD (32'h10801080)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .din        (din),
    .dvalid     (dvalid),
    .clear_err  (clear_err),
    .dout       (dout),
    .dreq       (dreq),
    .line       (line),
    .field_odd  (field_odd),
    .vblank     (vblank),
    .hactive    (hactive),
    .frame_start(frame_start),
    .underflow  (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle(input string tag);
    chk({tag, "_dreq"}, {31'd0, dreq}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_dout"}, dout, BLANK);
    chk({tag, "_hact"}, {31'd0, hactive}, 32'd0);
    chk({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
  endtask

  // Drives one full 8-word line; miss is the active index with dvalid low (-1 for none).
  task automatic line_run(input int ln, input logic [31:0] eav, input logic [31:0] sav,
                          input logic f, input logic v, input int miss);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] exp_out;
      logic        exp_req;
      int          a;
      a       = k - 4;
      exp_req = (k >= 4) && !v;
      if (k >= 4) begin
        din    = 32'((ln - 1) * 16 + a + 1);
        dvalid = (a != miss);
      end else begin
        din    = 32'hDEADBEEF;
        dvalid = 1'b1;
      end
      if (k == 0) exp_out = eav;
      else if (k == 3) exp_out = sav;
      else if (k >= 4 && !v && a != miss) exp_out = din;
      else exp_out = BLANK;
      chk($sformatf("dreq_l%0d_w%0d", ln, k), {31'd0, dreq}, {31'd0, exp_req});
      @(posedge clk);
      #1;
      chk($sformatf("dout_l%0d_w%0d", ln, k), dout, exp_out);
      chk($sformatf("hact_l%0d_w%0d", ln, k), {31'd0, hactive}, {31'd0, k >= 4});
      chk($sformatf("fs_l%0d_w%0d", ln, k), {31'd0, frame_start}, {31'd0, (ln == 0 && k == 0)});
      if (k == 0) begin
        chk($sformatf("line_l%0d", ln), {29'd0, line}, 32'(ln));
        chk($sformatf("field_l%0d", ln), {31'd0, field_odd}, {31'd0, f});
        chk($sformatf("vblank_l%0d", ln), {31'd0, vblank}, {31'd0, v});
      end
      if (k >= 4 && a == miss) begin
        chk($sformatf("uf_set_l%0d", ln), {31'd0, underflow}, 32'd1);
      end
    end
    dvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    din       = '0;
    dvalid    = 1'b0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, BLANK);
    chk("rst_line", {29'd0, line}, 32'd0);
    chk("rst_field", {31'd0, field_odd}, 32'd0);
    chk("rst_vblank", {31'd0, vblank}, 32'd0);
    chk("rst_hact", {31'd0, hactive}, 32'd0);
    chk("rst_fs", {31'd0, frame_start}, 32'd0);
    chk("rst_uf", {31'd0, underflow}, 32'd0);
    chk("rst_dreq", {31'd0, dreq}, 32'd0);
    rst = 1'b0;
    repeat (4) idle_cycle("idle0");

    // Frame 1: enable dropped on line 2, underflow on line 2.
    enable = 1'b1;
    line_run(0, 32'hB60000FF, 32'hAB0000FF, 1'b0, 1'b1, -1);
    line_run(1, 32'h9D0000FF, 32'h800000FF, 1'b0, 1'b0, -1);
    enable = 1'b0;
    line_run(2, 32'h9D0000FF, 32'h800000FF, 1'b0, 1'b0, 1);
    chk("uf_hold_l2", {31'd0, underflow}, 32'd1);
    line_run(3, 32'hF10000FF, 32'hEC0000FF, 1'b1, 1'b1, -1);
    line_run(4, 32'hDA0000FF, 32'hC70000FF, 1'b1, 1'b0, -1);
    line_run(5, 32'hDA0000FF, 32'hC70000FF, 1'b1, 1'b0, -1);
    repeat (3) idle_cycle("idle1");
    chk("uf_hold_idle", {31'd0, underflow}, 32'd1);
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
    chk("uf_cleared", {31'd0, underflow}, 32'd0);

    // Frame 2 with enable held: wraps into frame 3; set beats clear on line 2.
    enable = 1'b1;
    line_run(0, 32'hB60000FF, 32'hAB0000FF, 1'b0, 1'b1, -1);
    line_run(1, 32'h9D0000FF, 32'h800000FF, 1'b0, 1'b0, -1);
    clear_err = 1'b1;
    line_run(2, 32'h9D0000FF, 32'h800000FF, 1'b0, 1'b0, 1);
    chk("uf_clear_after_set", {31'd0, underflow}, 32'd0);
    clear_err = 1'b0;
    line_run(3, 32'hF10000FF, 32'hEC0000FF, 1'b1, 1'b1, -1);
    line_run(4, 32'hDA0000FF, 32'hC70000FF, 1'b1, 1'b0, -1);
    line_run(5, 32'hDA0000FF, 32'hC70000FF, 1'b1, 1'b0, -1);
    line_run(0, 32'hB60000FF, 32'hAB0000FF, 1'b0, 1'b1, -1);
    enable = 1'b0;
    line_run(1, 32'h9D0000FF, 32'h800000FF, 1'b0, 1'b0, -1);
    line_run(2, 32'h9D0000FF, 32'h800000FF, 1'b0, 1'b0, -1);
    line_run(3, 32'hF10000FF, 32'hEC0000FF, 1'b1, 1'b1, -1);
    line_run(4, 32'hDA0000FF, 32'hC70000FF, 1'b1, 1'b0, -1);
    line_run(5, 32'hDA0000FF, 32'hC70000FF, 1'b1, 1'b0, -1);
    repeat (2) idle_cycle("idle2");

    // Reset mid-line aborts the frame; no restart without enable.
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    chk("mid_rst_dout", dout, BLANK);
    chk("mid_rst_vblank", {31'd0, vblank}, 32'd0);
    chk("mid_rst_hact", {31'd0, hactive}, 32'd0);
    chk("mid_rst_line", {29'd0, line}, 32'd0);
    chk("mid_rst_dreq", {31'd0, dreq}, 32'd0);
    #1;
    rst = 1'b0;
    repeat (3) idle_cycle("idle3");
    enable = 1'b1;
    line_run(0, 32'hB60000FF, 32'hAB0000FF, 1'b0, 1'b1, -1);
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_stream_framer.md
VIDEO_STREAM_FRAMER -- requirements
Module: video_stream_framer

Interface
REQ-001 SHALL have parameter HACTIVE, default 360, meaning 32-bit active words per line (2 pixels per word, 4:2:2).
REQ-002 SHALL have parameter HBLANK, default 67, meaning blank words between EAV and SAV.
REQ-003 SHALL have parameter TOTAL_LINES, default 525, meaning lines per frame, numbered 0..TOTAL_LINES-1.
REQ-004 SHALL have parameter F1_START, default 263, meaning the first line with F=1; INTERLACED=0 forces F=0.
REQ-005 SHALL have parameter V0_END, default 19, meaning lines below this value have V=1.
REQ-006 SHALL have parameter V1_END, default 282, meaning lines in [F1_START, V1_END) have V=1.
REQ-007 SHALL have parameter INTERLACED, default 1, meaning field bit enable.
REQ-008 SHALL have parameter BLANK_WORD, default 32'h10801080, meaning the blanking/filler word.
REQ-009 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-010 Reset  input  1  asynchronous, active-high reset.
REQ-011 Enable  input  1  starts framing; it is sampled only in IDLE and at frame end.
REQ-012 DIn  input  32  active video word from upstream.
REQ-013 DValid  input  1  DIn is valid this cycle.
REQ-014 ClearErr  input  1  synchronous clear of Underflow.
REQ-015 DOut  output  32  registered stream output.
REQ-016 DReq  output  1  combinational; upstream SHALL present DIn/DValid in the same cycle.
REQ-017 Line  output  $clog2(TOTAL_LINES)  current line of the word being emitted on DOut.
REQ-018 FieldOdd, VBlank, HActive  output  1 each  registered F, V, and active-word flag aligned with DOut.
REQ-019 FrameStart  output  1  one-cycle pulse aligned with the EAV of line 0.
REQ-020 Underflow  output  1  sticky flag.

Function
REQ-021 Position counters: word counter WPOS 0..HACTIVE+HBLANK+1 and line counter LPOS 0..TOTAL_LINES-1, with widths set by $clog2.
REQ-022 Line layout: WPOS=0 is EAV; 1..HBLANK is blank; HBLANK+1 is SAV; HBLANK+2..HBLANK+1+HACTIVE is active.
REQ-023 F = INTERLACED & (LPOS>=F1_START).
REQ-024 V = (LPOS<V0_END) | (LPOS>=F1_START & LPOS<V1_END).
REQ-025 Header word = {1, F, V, H, V^H, F^H, F^V, F^V^H, 24'h0000FF}; H=1 for EAV and H=0 for SAV.
REQ-026 FSM states: IDLE and RUN.
- IDLE: counters held at 0; DOut=BLANK_WORD; DReq=0.
- IDLE & Enable: go to RUN; the next DOut is the EAV of line 0.
REQ-027 RUN: WPOS increments every cycle; at the last word WPOS wraps to 0 and LPOS increments.
- At the last word of the last line, LPOS wraps to 0.
- At that last word, the FSM stays in RUN if Enable=1, else goes to IDLE.
- Enable deassertion mid-frame SHALL be ignored; the frame always completes.
REQ-028 DReq = RUN & active word & ~V.
REQ-029 DOut is registered from the current position, giving 1-cycle latency.
- Active word with DValid: DOut = DIn.
- Active word during V=1: DOut = BLANK_WORD.
- Blank words: DOut = BLANK_WORD.
REQ-030 If DReq=1 and DValid=0: DOut = BLANK_WORD and Underflow is set.
REQ-031 Underflow SHALL stay set until ClearErr or Reset.
- If set and clear occur in the same cycle, set wins.
REQ-032 DValid while DReq=0 SHALL be ignored.
REQ-033 HActive=1 exactly for active-word cycles on DOut, including cycles inside V=1.

Reset
REQ-034 Reset SHALL asynchronously force the following.
- FSM to IDLE; WPOS=0; LPOS=0.
- DOut=BLANK_WORD; Line=0.
- FieldOdd, VBlank, HActive, FrameStart and Underflow all to 0.
REQ-035 Reset mid-line SHALL abort the frame immediately; restart requires Enable after release.

Verification
(Parameters: HACTIVE=4, HBLANK=2, TOTAL_LINES=6, F1_START=3, V0_END=1, V1_END=4, INTERLACED=1; 8 words/line.)
REQ-036 Reset release with Enable=0 -> DOut=32'h10801080 held, and DReq=0 indefinitely.
REQ-037 Enable=1 from IDLE -> line 0 DOut sequence is B60000FF, 10801080, 10801080, AB0000FF, then 4x 10801080.
- FrameStart is high with the first word.
- DReq stays 0 (V=1).
REQ-038 Line 1 with DValid=1 and DIn=00000001..00000004 -> DOut is 9D0000FF, blank, blank, 800000FF, 00000001..00000004.
- DReq is high for 4 cycles.
REQ-039 Line 3 -> EAV F10000FF and SAV EC0000FF.
- Line 4 -> EAV DA0000FF and SAV C70000FF.
- Line 4 has FieldOdd=1.
REQ-040 DValid=0 on one active word of line 2 -> that DOut=10801080 and Underflow=1.
- Underflow persists until ClearErr, then returns to 0.
REQ-041 Enable dropped on line 2 -> frame completes through line 5.
- Afterwards: IDLE, DOut=10801080, and no FrameStart.
- Enable held high instead -> wraps to line 0, with FrameStart pulsing every 48 cycles.
